// File: rtl/dsi_packet_parser.sv
// rtl/dsi_packet_parser.sv - receive-side DSI packet decoder with header ECC correction and payload CRC check
//
// Splits one merged-lane HS burst (one byte per clk) into DSI packets.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_data/in_valid/in_sot/in_last   burst byte stream, sot/last qualified by in_valid
//   hdr_valid/hdr_vc/hdr_dt/hdr_wc/hdr_long   accepted header (1-clk pulse + fields)
//   pay_data/pay_valid/pay_last   payload byte stream of long packets
//   pkt_done/crc_ok               long packet end and CRC result
//   err_pulse                     {wc, truncated, ecc_uncorrectable, ecc_corrected}
//   cnt_clear/ecc_err_cnt/crc_err_cnt   saturating error counters
module dsi_packet_parser #(
  parameter bit          CHECK_CRC = 1'b1,
  parameter logic [15:0] MAX_WC    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sot,
  input  logic        in_last,
  output logic        hdr_valid,
  output logic [1:0]  hdr_vc,
  output logic [5:0]  hdr_dt,
  output logic [15:0] hdr_wc,
  output logic        hdr_long,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  output logic        pay_last,
  output logic        pkt_done,
  output logic        crc_ok,
  output logic [3:0]  err_pulse,
  input  logic        cnt_clear,
  output logic [15:0] ecc_err_cnt,
  output logic [15:0] crc_err_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_PAY   = 3'd2;
  localparam logic [2:0] S_CRC   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // Widened by one bit so the compare stays meaningful even when MAX_WC is all ones.
  localparam logic [16:0] MAX_WC_X = {1'b0, MAX_WC};

  // DSI header ECC: parity bit k covers the data bits set in its mask.
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    return {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction

  // CRC16-CCITT, reflected (LSB first) form.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (((r[0] ^ b[i]) != 1'b0) ? 16'h8408 : 16'h0000);
    end
    return r;
  endfunction

  logic [2:0]  state;
  logic [1:0]  hdr_cnt;
  logic [23:0] hdr_buf;
  logic [15:0] wc_cnt;
  logic [15:0] crc_calc;
  logic [7:0]  crc_lo;
  logic        crc_cnt;

  // in_sot restarts header collection regardless of where the FSM is.
  logic [2:0]  eff_state;
  logic [1:0]  eff_idx;
  assign eff_state = in_sot ? S_HDR : state;
  assign eff_idx   = in_sot ? 2'd0 : hdr_cnt;

  logic [5:0]  syndrome;
  logic [23:0] hdr_fix;
  logic        syn_data_hit;
  logic        ecc_corr;
  logic        ecc_bad;
  logic        fix_long;
  logic        wc_big;
  logic        crc_match;

  assign syndrome = ecc6(hdr_buf) ^ in_data[5:0];

  // A syndrome equal to a data-bit column flips that bit; a one-hot syndrome
  // is an error in the ECC byte itself, so the data is already right.
  always_comb begin
    hdr_fix      = hdr_buf;
    syn_data_hit = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (syndrome == ecc6(24'(1) << i)) begin
        hdr_fix[i]   = ~hdr_buf[i];
        syn_data_hit = 1'b1;
      end
    end
  end

  assign ecc_corr  = syn_data_hit || $onehot(syndrome);
  assign ecc_bad   = (syndrome != 6'd0) && !ecc_corr;
  assign fix_long  = hdr_fix[3] && (hdr_fix[2:0] != 3'd0);
  assign wc_big    = {1'b0, hdr_fix[23:8]} > MAX_WC_X;
  assign crc_match = !CHECK_CRC || ({in_data, crc_lo} == crc_calc);

  logic hdr_end;
  logic crc_end;
  assign hdr_end = in_valid && (eff_state == S_HDR) && (eff_idx == 2'd3);
  assign crc_end = in_valid && !in_sot && (state == S_CRC) && crc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hdr_cnt   <= 2'd0;
      hdr_buf   <= 24'd0;
      wc_cnt    <= 16'd0;
      crc_calc  <= 16'hFFFF;
      crc_lo    <= 8'd0;
      crc_cnt   <= 1'b0;
      hdr_valid <= 1'b0;
      hdr_vc    <= 2'd0;
      hdr_dt    <= 6'd0;
      hdr_wc    <= 16'd0;
      hdr_long  <= 1'b0;
      pay_data  <= 8'd0;
      pay_valid <= 1'b0;
      pay_last  <= 1'b0;
      pkt_done  <= 1'b0;
      crc_ok    <= 1'b0;
      err_pulse <= 4'd0;
    end else begin
      hdr_valid <= 1'b0;
      pay_valid <= 1'b0;
      pay_last  <= 1'b0;
      pkt_done  <= 1'b0;
      err_pulse <= 4'd0;
      if (in_valid) begin
        if (in_sot && state != S_IDLE && state != S_DRAIN) err_pulse[2] <= 1'b1;
        case (eff_state)
          S_IDLE: ;
          S_DRAIN: if (in_last) state <= S_IDLE;
          S_HDR: begin
            if (eff_idx != 2'd3) begin
              hdr_buf[8*eff_idx +: 8] <= in_data;
              hdr_cnt <= eff_idx + 2'd1;
              state   <= in_last ? S_IDLE : S_HDR;
              if (in_last) err_pulse[2] <= 1'b1;
            end else begin
              hdr_cnt <= 2'd0;
              if (ecc_bad) begin
                err_pulse[1] <= 1'b1;
                state        <= in_last ? S_IDLE : S_DRAIN;
              end else begin
                err_pulse[0] <= ecc_corr;
                hdr_valid    <= 1'b1;
                hdr_vc       <= hdr_fix[7:6];
                hdr_dt       <= hdr_fix[5:0];
                hdr_wc       <= hdr_fix[23:8];
                hdr_long     <= fix_long;
                wc_cnt       <= hdr_fix[23:8];
                crc_calc     <= 16'hFFFF;
                crc_cnt      <= 1'b0;
                if (fix_long && wc_big) begin
                  err_pulse[3] <= 1'b1;
                  state        <= in_last ? S_IDLE : S_DRAIN;
                end else if (!fix_long) begin
                  state <= in_last ? S_IDLE : S_HDR;
                end else if (in_last) begin
                  err_pulse[2] <= 1'b1;
                  state        <= S_IDLE;
                end else begin
                  state <= (hdr_fix[23:8] == 16'd0) ? S_CRC : S_PAY;
                end
              end
            end
          end
          S_PAY: begin
            pay_valid <= 1'b1;
            pay_data  <= in_data;
            crc_calc  <= crc16_byte(crc_calc, in_data);
            wc_cnt    <= wc_cnt - 16'd1;
            if (in_last) begin
              err_pulse[2] <= 1'b1;
              state        <= S_IDLE;
            end else if (wc_cnt == 16'd1) begin
              pay_last <= 1'b1;
              state    <= S_CRC;
            end
          end
          S_CRC: begin
            if (!crc_cnt) begin
              crc_lo  <= in_data;
              crc_cnt <= 1'b1;
              if (in_last) begin
                err_pulse[2] <= 1'b1;
                state        <= S_IDLE;
              end
            end else begin
              crc_cnt  <= 1'b0;
              pkt_done <= 1'b1;
              crc_ok   <= crc_match;
              state    <= in_last ? S_IDLE : S_HDR;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ecc_err_cnt <= 16'd0;
      crc_err_cnt <= 16'd0;
    end else if (cnt_clear) begin
      ecc_err_cnt <= 16'd0;
      crc_err_cnt <= 16'd0;
    end else begin
      if (hdr_end && ecc_bad && ecc_err_cnt != 16'hFFFF) ecc_err_cnt <= ecc_err_cnt + 16'd1;
      if (crc_end && !crc_match && crc_err_cnt != 16'hFFFF) crc_err_cnt <= crc_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dsi_packet_parser.sv
// tb/tb_dsi_packet_parser.sv - scoreboard bench for dsi_packet_parser
module tb_dsi_packet_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_sot = 1'b0;
  logic        in_last = 1'b0;
  logic        hdr_valid;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        hdr_long;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        pay_last;
  logic        pkt_done;
  logic        crc_ok;
  logic [3:0]  err_pulse;
  logic        cnt_clear = 1'b0;
  logic [15:0] ecc_err_cnt;
  logic [15:0] crc_err_cnt;

  int errors = 0;
  int checks = 0;

  logic [24:0] hdr_q[$];
  logic [8:0]  pay_q[$];
  logic        done_q[$];
  logic [3:0]  err_q[$];

  dsi_packet_parser #(.CHECK_CRC(1'b1), .MAX_WC(16'd64)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sot(in_sot), .in_last(in_last),
    .hdr_valid(hdr_valid), .hdr_vc(hdr_vc), .hdr_dt(hdr_dt), .hdr_wc(hdr_wc), .hdr_long(hdr_long),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_last(pay_last),
    .pkt_done(pkt_done), .crc_ok(crc_ok), .err_pulse(err_pulse),
    .cnt_clear(cnt_clear), .ecc_err_cnt(ecc_err_cnt), .crc_err_cnt(crc_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Header ECC written out as the parity equations.
  function automatic logic [7:0] m_ecc(input logic [23:0] d);
    logic [7:0] e;
    e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    e[7:6] = 2'b00;
    return e;
  endfunction

  // Byte-wise CRC-CCITT (reflected), table-free form.
  function automatic logic [15:0] m_crc(input logic [15:0] crc, input logic [7:0] b);
    logic [7:0] x;
    x = b ^ crc[7:0];
    x = x ^ (x << 4);
    return ({x, crc[15:8]}) ^ {8'd0, (x >> 4)} ^ ({8'd0, x} << 3);
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic sot, input logic last);
    in_data = d; in_valid = 1'b1; in_sot = sot; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sot = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [23:0] flip,
                          input logic sot, input logic last);
    logic [23:0] d;
    logic [7:0]  e;
    e = m_ecc({wc, di});
    d = {wc, di} ^ flip;
    send_byte(d[7:0], sot, 1'b0);
    send_byte(d[15:8], 1'b0, 1'b0);
    send_byte(d[23:16], 1'b0, 1'b0);
    send_byte(e, 1'b0, last);
  endtask

  // Monitor: pops an expectation for every output event the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid) begin
        if (hdr_q.size() == 0) check("hdr_unexpected", {7'd0, hdr_vc, hdr_dt, hdr_wc, hdr_long}, 32'hFFFFFFFF);
        else check("hdr", {7'd0, hdr_vc, hdr_dt, hdr_wc, hdr_long}, {7'd0, hdr_q.pop_front()});
      end
      if (pay_valid) begin
        if (pay_q.size() == 0) check("pay_unexpected", {23'd0, pay_last, pay_data}, 32'hFFFFFFFF);
        else check("pay", {23'd0, pay_last, pay_data}, {23'd0, pay_q.pop_front()});
      end
      if (pkt_done) begin
        if (done_q.size() == 0) check("done_unexpected", {31'd0, crc_ok}, 32'hFFFFFFFF);
        else check("crc_ok", {31'd0, crc_ok}, {31'd0, done_q.pop_front()});
      end
      if (err_pulse != 4'd0) begin
        if (err_q.size() == 0) check("err_unexpected", {28'd0, err_pulse}, 32'hFFFFFFFF);
        else check("err_pulse", {28'd0, err_pulse}, {28'd0, err_q.pop_front()});
      end
    end
  end

  initial begin
    logic [15:0] crc;
    idle(3);
    check("rst_hdr_valid", {31'd0, hdr_valid}, 32'd0);
    check("rst_hdr_wc", {16'd0, hdr_wc}, 32'd0);
    check("rst_pay", {22'd0, pay_valid, pay_last, pay_data}, 32'd0);
    check("rst_done_crc", {30'd0, pkt_done, crc_ok}, 32'd0);
    check("rst_err", {28'd0, err_pulse}, 32'd0);
    check("rst_cnts", {ecc_err_cnt, crc_err_cnt}, 32'd0);
    rst = 1'b0;
    idle(2);

    // 1: short packet ending the burst; following bytes without SoT are ignored
    hdr_q.push_back({2'd0, 6'h15, 16'h0036, 1'b0});
    send_hdr(8'h15, 16'h0036, 24'd0, 1'b1, 1'b1);
    send_hdr(8'h15, 16'h0036, 24'd0, 1'b0, 1'b0);
    idle(2);

    // 2: long packet WC=3 with a gap inside the payload, good CRC
    crc = 16'hFFFF;
    crc = m_crc(crc, 8'hA5); crc = m_crc(crc, 8'h5A); crc = m_crc(crc, 8'hFF);
    hdr_q.push_back({2'd0, 6'h39, 16'h0003, 1'b1});
    pay_q.push_back({1'b0, 8'hA5}); pay_q.push_back({1'b0, 8'h5A}); pay_q.push_back({1'b1, 8'hFF});
    done_q.push_back(1'b1);
    send_hdr(8'h39, 16'h0003, 24'd0, 1'b1, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    idle(2);
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(crc[7:0], 1'b0, 1'b0);
    send_byte(crc[15:8], 1'b0, 1'b1);
    idle(3);
    check("crc_err_cnt_good", {16'd0, crc_err_cnt}, 32'd0);

    // 3: same packet with a flipped payload bit
    hdr_q.push_back({2'd0, 6'h39, 16'h0003, 1'b1});
    pay_q.push_back({1'b0, 8'hA4}); pay_q.push_back({1'b0, 8'h5A}); pay_q.push_back({1'b1, 8'hFF});
    done_q.push_back(1'b0);
    send_hdr(8'h39, 16'h0003, 24'd0, 1'b1, 1'b0);
    send_byte(8'hA4, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(crc[7:0], 1'b0, 1'b0);
    send_byte(crc[15:8], 1'b0, 1'b1);
    idle(3);
    check("crc_err_cnt_bad", {16'd0, crc_err_cnt}, 32'd1);
    cnt_clear = 1'b1; idle(1); cnt_clear = 1'b0;
    idle(1);
    check("crc_err_cnt_clr", {16'd0, crc_err_cnt}, 32'd0);

    // 4: single-bit error in WC bit 4 corrected, then a 2-bit error drained to in_last
    hdr_q.push_back({2'd0, 6'h15, 16'h0036, 1'b0});
    err_q.push_back(4'b0001);
    err_q.push_back(4'b0010);
    send_hdr(8'h15, 16'h0036, 24'h001000, 1'b1, 1'b0);
    send_hdr(8'h15, 16'h0036, 24'h000003, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b1);
    idle(3);
    check("ecc_err_cnt", {16'd0, ecc_err_cnt}, 32'd1);

    // 5: short (VC1) + long WC=0 + EoTp in one burst
    hdr_q.push_back({2'd1, 6'h05, 16'h3412, 1'b0});
    hdr_q.push_back({2'd0, 6'h29, 16'h0000, 1'b1});
    hdr_q.push_back({2'd0, 6'h08, 16'h0F0F, 1'b0});
    done_q.push_back(1'b1);
    send_hdr(8'h45, 16'h3412, 24'd0, 1'b1, 1'b0);
    send_hdr(8'h29, 16'h0000, 24'd0, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_hdr(8'h08, 16'h0F0F, 24'd0, 1'b0, 1'b1);
    idle(3);
    check("crc_err_cnt_wc0", {16'd0, crc_err_cnt}, 32'd0);

    // 6: in_last on 2nd payload byte, then SoT in the middle of a header
    hdr_q.push_back({2'd0, 6'h29, 16'h000A, 1'b1});
    pay_q.push_back({1'b0, 8'h11}); pay_q.push_back({1'b0, 8'h22});
    err_q.push_back(4'b0100);
    send_hdr(8'h29, 16'h000A, 24'd0, 1'b1, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b1);
    idle(2);
    err_q.push_back(4'b0100);
    hdr_q.push_back({2'd0, 6'h15, 16'h0036, 1'b0});
    send_byte(8'h15, 1'b1, 1'b0);
    send_byte(8'h36, 1'b0, 1'b0);
    send_hdr(8'h15, 16'h0036, 24'd0, 1'b1, 1'b1);
    idle(2);

    // 7: WC above MAX_WC flags err_wc with the header, rest of burst dropped
    hdr_q.push_back({2'd0, 6'h29, 16'h00C8, 1'b1});
    err_q.push_back(4'b1000);
    send_hdr(8'h29, 16'h00C8, 24'd0, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b1);
    idle(5);

    check("hdr_q_left", hdr_q.size(), 32'd0);
    check("pay_q_left", pay_q.size(), 32'd0);
    check("done_q_left", done_q.size(), 32'd0);
    check("err_q_left", err_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
